lb2spi_master: RTL

SPI master (mode 0, MSB first) that turns local-bus-style read/write requests into SPI frames for the on-chip spi2lb register-map slave. Used in test harnesses, and on host-side FPGAs, to drive the rmap CSR block over its SPI pins. One outstanding request at a time. Every request gets exactly one response pulse, including writes.

---
 rtl/lb2spi_pkg.sv | 26 ++
 rtl/spi_sck_gen.sv | 39 +++
 rtl/lb2spi_master.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lb2spi_pkg.sv
// Shared command codes, FSM state encoding and frame-length helper for the
// local-bus to SPI master.
package lb2spi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Number of SCK cycles in one frame; reads carry the dummy field.
  function automatic int frame_len(input logic is_write, input int addr_w,
                                   input int data_w, input int dummy_w);
    if (is_write) begin
      return 32'd8 + addr_w + data_w;
    end else begin
      return 32'd8 + addr_w + dummy_w + data_w;
    end
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period generator. Free-runs while enabled and parks SCK low
// otherwise.
module spi_sck_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(SCK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          sck_r;

  // Half-period counter; SCK toggles when the counter wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt_r <= '0;
      sck_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      sck_r <= ~sck_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // rise_tick marks the first high cycle, fall_tick the last high cycle
  // (SCK drops at the following edge).
  assign sck       = sck_r;
  assign rise_tick = en && sck_r && (cnt_r == '0);
  assign fall_tick = en && sck_r && (cnt_r == CNT_LAST);

endmodule

// File: rtl/lb2spi_master.sv
// Mode-0, MSB-first SPI master that turns single local-bus read/write
// requests into command/address/data frames for the spi2lb slave.
module lb2spi_master
  import lb2spi_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int SCK_DIV = 4,
  parameter int DUMMY_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int N_WR      = frame_len(1'b1, ADDR_W, DATA_W, DUMMY_W);
  localparam int N_RD      = frame_len(1'b0, ADDR_W, DATA_W, DUMMY_W);
  localparam int FRAME_MAX = (N_RD > N_WR) ? N_RD : N_WR;
  localparam int BCW       = $clog2(FRAME_MAX + 1);
  localparam int PCW       = $clog2(SCK_DIV + 1);

  localparam logic [PCW-1:0] PH_LAST = PCW'(SCK_DIV - 1);
  localparam logic [BCW-1:0] WR_LAST = BCW'(N_WR - 1);
  localparam logic [BCW-1:0] RD_LAST = BCW'(N_RD - 1);

  if (SCK_DIV < 2) begin : g_bad_div
    $error("lb2spi_master: SCK_DIV must be at least 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("lb2spi_master: DATA_W must be a multiple of 8");
  end

  state_e               state_r;
  logic [PCW-1:0]       phase_r;
  logic [BCW-1:0]       bit_r;
  logic [BCW-1:0]       bit_last_r;
  logic [FRAME_MAX-1:0] tx_r;
  logic [DATA_W-1:0]    rx_r;
  logic                 is_read_r;
  logic                 ready_r;
  logic                 rsp_valid_r;
  logic [DATA_W-1:0]    rdata_r;
  logic                 cs_n_r;
  logic                 mosi_r;

  logic [FRAME_MAX-1:0] frame_s;
  logic                 sck_en_s;
  logic                 rise_tick_s;
  logic                 fall_tick_s;

  // Left-aligned outgoing frame; dummy and read-data slots shift out as zeros.
  always_comb begin
    frame_s = '0;
    if (req_write) begin
      frame_s = FRAME_MAX'({CMD_WRITE, req_addr, req_wdata}) << (FRAME_MAX - N_WR);
    end else begin
      frame_s = FRAME_MAX'({CMD_READ, req_addr}) << (FRAME_MAX - 8 - ADDR_W);
    end
  end

  assign sck_en_s = (state_r == LEAD) || (state_r == XFER);

  spi_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (sck_en_s),
    .sck       (spi_sck),
    .rise_tick (rise_tick_s),
    .fall_tick (fall_tick_s)
  );

  // Frame sequencer: handshake, chip select, MOSI shift, MISO capture, response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      phase_r     <= '0;
      bit_r       <= '0;
      bit_last_r  <= '0;
      tx_r        <= '0;
      rx_r        <= '0;
      is_read_r   <= 1'b0;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= '0;
      cs_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          ready_r <= 1'b1;
          if (req_valid && ready_r) begin
            ready_r    <= 1'b0;
            state_r    <= LEAD;
            phase_r    <= '0;
            bit_r      <= '0;
            bit_last_r <= req_write ? WR_LAST : RD_LAST;
            is_read_r  <= !req_write;
            tx_r       <= frame_s << 1;
            mosi_r     <= frame_s[FRAME_MAX-1];
            cs_n_r     <= 1'b0;
          end
        end
        LEAD: begin
          if (phase_r == PH_LAST) begin
            phase_r <= '0;
            state_r <= XFER;
          end else begin
            phase_r <= phase_r + PCW'(1);
          end
        end
        XFER: begin
          if (rise_tick_s) begin
            rx_r <= {rx_r[DATA_W-2:0], spi_miso};
          end
          // MOSI moves with the falling edge; the final bit is simply held.
          if (fall_tick_s) begin
            if (bit_r == bit_last_r) begin
              state_r <= TRAIL;
              phase_r <= '0;
            end else begin
              bit_r  <= bit_r + BCW'(1);
              mosi_r <= tx_r[FRAME_MAX-1];
              tx_r   <= tx_r << 1;
            end
          end
        end
        TRAIL: begin
          if (phase_r == PH_LAST) begin
            phase_r     <= '0;
            state_r     <= GAP;
            cs_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            rsp_valid_r <= 1'b1;
            if (is_read_r) begin
              rdata_r <= rx_r;
            end else begin
              rdata_r <= rdata_r;
            end
          end else begin
            phase_r <= phase_r + PCW'(1);
          end
        end
        GAP: begin
          if (phase_r == PH_LAST) begin
            phase_r <= '0;
            state_r <= IDLE;
            ready_r <= 1'b1;
          end else begin
            phase_r <= phase_r + PCW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          phase_r <= '0;
          cs_n_r  <= 1'b1;
          mosi_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign spi_cs_n  = cs_n_r;
  assign spi_mosi  = mosi_r;

endmodule
